// File: rtl/clk_handoff_pkg.sv
// Shared constants and helpers for the clk_handoff fast-to-slow word handoff.
package clk_handoff_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  // Ceiling log2. Used for FIFO pointer widths.
  function automatic int ptr_w(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/clk_handoff_sync_fifo.sv
// Single-clock FIFO used by clk_handoff: storage, wrapping pointers and occupancy count.
module sync_fifo
  import clk_handoff_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full
);

  localparam int AW = ptr_w(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              push_ok, pop_ok;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Storage is not reset; pointer reset is what discards queued words.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/clk_handoff.sv
// Hands words from the fast clk domain to a slow clock sampled as data; outputs change on its falling edge.
// Define CLK_HANDOFF_SYNC_EN to pass clk_slow through a two-flop synchronizer first.
module clk_handoff
  import clk_handoff_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_slow,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              overflow
);

  logic              slow_s, slow_q, fall;
  logic              fifo_empty, fifo_full, pop;
  logic [DATA_W-1:0] head_data;

`ifdef CLK_HANDOFF_SYNC_EN
  logic [1:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], clk_slow};
  end

  assign slow_s = sync_pipe[1];
`else
  // Only valid when clk_slow is generated synchronously to clk.
  assign slow_s = clk_slow;
`endif

  always_ff @(posedge clk) begin
    if (rst) slow_q <= 1'b0;
    else     slow_q <= slow_s;
  end

  assign fall     = slow_q & ~slow_s;
  assign pop      = fall & ~fifo_empty;
  assign in_ready = ~fifo_full;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Updating only on fall keeps out_data stable across the next slow rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (fall) begin
      out_valid <= ~fifo_empty;
      if (!fifo_empty) out_data <= head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                        overflow <= 1'b0;
    else if (in_valid && fifo_full) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_clk_handoff.sv
// Self-checking bench for clk_handoff: queue scoreboard plus directed boundary checks.
module tb_clk_handoff;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
`ifdef CLK_HANDOFF_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, clk_slow, in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid, overflow;
  logic [DATA_W-1:0] out_data;
  bit                slow_en;

  int n_chk = 0;
  int n_fail = 0;

  clk_handoff #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_slow  (clk_slow),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slow clock: 4 clk high, 4 clk low, changed away from the clk edge; pinned high when disabled.
  initial begin
    int sc;
    sc = 0;
    clk_slow = 1'b1;
    forever begin
      @(posedge clk);
      #3;
      if (!slow_en) begin
        clk_slow = 1'b1;
        sc = 0;
      end else begin
        sc++;
        if (sc == 4) begin
          clk_slow = ~clk_slow;
          sc = 0;
        end
      end
    end
  end

  // Reference model and scoreboard, compared every cycle.
  logic [DATA_W-1:0] exp_q[$];
  logic              m_s1, m_s2, m_slow_q, m_valid, m_ovf;
  logic [DATA_W-1:0] m_data;

  initial begin
    logic s_cur, m_fall, m_full;
    m_s1 = 0; m_s2 = 0; m_slow_q = 0; m_valid = 0; m_ovf = 0; m_data = '0;
    forever begin
      @(posedge clk);
      s_cur  = SYNC ? m_s2 : clk_slow;
      m_fall = m_slow_q && !s_cur;
      if (rst) begin
        exp_q.delete();
        m_s1 = 0; m_s2 = 0; m_slow_q = 0; m_valid = 0; m_ovf = 0; m_data = '0;
      end else begin
        m_full = (exp_q.size() == DEPTH);
        if (m_fall) begin
          if (exp_q.size() > 0) begin
            m_data  = exp_q.pop_front();
            m_valid = 1'b1;
          end else begin
            m_valid = 1'b0;
          end
        end
        if (in_valid && !m_full) exp_q.push_back(in_data);
        if (in_valid && m_full)  m_ovf = 1'b1;
        m_slow_q = s_cur;
        m_s2     = m_s1;
        m_s1     = clk_slow;
      end
      #1;
      chk("sb_out_valid", out_valid, m_valid);
      chk("sb_out_data",  out_data,  m_data);
      chk("sb_in_ready",  in_ready,  exp_q.size() != DEPTH);
      chk("sb_overflow",  overflow,  m_ovf);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge just before a clk edge on which the model predicts a fall.
  task automatic wait_fall();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (m_slow_q && !(SYNC ? m_s2 : clk_slow)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("fall_wait", ok, 1'b1);
  endtask

  task automatic fill(input logic [DATA_W-1:0] base, input int n);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data = base + DATA_W'(i);
      cyc(1);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  seen;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; slow_en = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data",  out_data,  8'h00);
    chk("rst_overflow",  overflow,  1'b0);

    // Idle for three slow periods.
    slow_en = 1'b1;
    cyc(24);
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_out_data",  out_data,  8'h00);
    chk("idle_in_ready",  in_ready,  1'b1);

    // Two words, each presented for exactly one slow period.
    slow_en = 1'b0;
    cyc(4);
    in_valid = 1'b1; in_data = 8'hA5; cyc(1);
    in_data = 8'h3C; cyc(1);
    in_valid = 1'b0;
    slow_en = 1'b1;
    wait_fall(); cyc(1);
    chk("two_w1_valid", out_valid, 1'b1);
    chk("two_w1_data",  out_data,  8'hA5);
    wait_fall(); cyc(1);
    chk("two_w2_data",  out_data,  8'h3C);
    wait_fall(); cyc(1);
    chk("two_end_valid", out_valid, 1'b0);
    chk("two_end_hold",  out_data,  8'h3C);

    // Five words into a 4-deep FIFO with no slow falls.
    slow_en = 1'b0;
    cyc(4);
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_data = DATA_W'(i);
      cyc(1);
      if (i == 4) chk("fill_ready_low", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    chk("fill_overflow", overflow, 1'b1);
    slow_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_fall(); cyc(1);
      chk("fill_order", out_data, 32'(i));
    end
    wait_fall(); cyc(1);
    chk("fill_drained", out_valid, 1'b0);

    // Full FIFO with a push offered on the fall edge.
    rst = 1'b1; cyc(1); rst = 1'b0;
    slow_en = 1'b0;
    cyc(4);
    fill(8'h40, 4);
    slow_en = 1'b1;
    wait_fall();
    in_valid = 1'b1; in_data = 8'h77;
    cyc(1);
    in_valid = 1'b0;
    chk("full_fall_ovf",   overflow, 1'b1);
    chk("full_fall_ready", in_ready, 1'b1);
    chk("full_fall_head",  out_data, 8'h40);
    for (int i = 0; i < 3; i++) begin
      wait_fall(); cyc(1);
    end
    chk("full_fall_last", out_data, 8'h43);

    // Push exactly on the fall edge while empty.
    wait_fall();
    in_valid = 1'b1; in_data = 8'h11;
    cyc(1);
    in_valid = 1'b0;
    chk("edge_push_valid", out_valid, 1'b0);
    wait_fall(); cyc(1);
    chk("edge_push_next_valid", out_valid, 1'b1);
    chk("edge_push_next_data",  out_data,  8'h11);

    // Reset with three words queued.
    slow_en = 1'b0;
    cyc(4);
    fill(8'h90, 3);
    rst = 1'b1; cyc(1); rst = 1'b0;
    slow_en = 1'b1;
    wait_fall(); cyc(1);
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_ovf",   overflow,  1'b0);

    // Output latency from the first clk edge that samples clk_slow low.
    slow_en = 1'b0;
    cyc(4);
    fill(8'h5A, 1);
    slow_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (clk_slow == 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("lat_slow_low", seen, 1'b1);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) break;
      lat++;
    end
    chk("latency", lat, SYNC ? 2 : 0);
    chk("lat_data", out_data, 8'h5A);

    cyc(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
